// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX core among NUM_REQ byte producers,
// with per-requester burst locking and a transmit watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT_CYC = 60000,
  localparam int unsigned GrantW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_lock,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     tx_en,
  output logic [WIDTH-1:0]         tx_data,
  input  logic                     tx_done,
  output logic [GrantW-1:0]        grant_id,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned WdW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e            state_q;
  logic [GrantW-1:0] ptr_q;
  logic              lock_q;
  logic [BurstW-1:0] burst_cnt_q;
  logic [WdW-1:0]    wd_cnt_q;

  logic              lock_active;
  logic              win_found;
  logic [GrantW-1:0] win_idx;
  logic [GrantW-1:0] cand;
  logic [WIDTH-1:0]  win_data;

  // A held lock restricts the grant to the current owner, even if it has no byte ready.
  always_comb begin
    win_found   = 1'b0;
    win_idx     = '0;
    cand        = '0;
    lock_active = lock_q && req_lock[grant_id] && (burst_cnt_q < BurstW'(MAX_BURST));
    if (lock_active) begin
      win_found = req_valid[grant_id];
      win_idx   = grant_id;
    end else begin
      for (int i = 1; i <= int'(NUM_REQ); i++) begin
        cand = GrantW'((int'(ptr_q) + i) % int'(NUM_REQ));
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_idx == GrantW'(i)) win_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && win_found) req_ready[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= GrantW'(NUM_REQ - 1);
      grant_id    <= '0;
      lock_q      <= 1'b0;
      burst_cnt_q <= '0;
      wd_cnt_q    <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (lock_q && !req_lock[grant_id]) lock_q <= 1'b0;
          if (win_found) begin
            tx_data     <= win_data;
            grant_id    <= win_idx;
            ptr_q       <= win_idx;
            lock_q      <= req_lock[win_idx];
            burst_cnt_q <= lock_active ? burst_cnt_q + BurstW'(1) : BurstW'(1);
            wd_cnt_q    <= '0;
            tx_en       <= 1'b1;
            busy        <= 1'b1;
            state_q     <= StIssue;
          end
        end
        // The watchdog starts counting in the tx_en cycle so that the flag rises
        // exactly TIMEOUT_CYC cycles after the start pulse.
        StIssue: begin
          wd_cnt_q <= wd_cnt_q + WdW'(1);
          state_q  <= StWait;
        end
        StWait: begin
          if (tx_done) begin
            if (burst_cnt_q >= BurstW'(MAX_BURST)) lock_q <= 1'b0;
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (wd_cnt_q == WdW'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            lock_q      <= 1'b0;
            busy        <= 1'b0;
            state_q     <= StIdle;
          end else begin
            wd_cnt_q <= wd_cnt_q + WdW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small serialising TX-core stub.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_lock, req_ready;
  logic [31:0] req_data;
  logic        tx_en, tx_done, busy, timeout_err, err_clr;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;

  int n_cmp  = 0;
  int n_fail = 0;

  // TX core stub: 2 clocks per bit, 10-bit frame, done pulse after the stop bit.
  logic       stub_auto, man_done, stub_busy, stub_done, serial;
  logic [9:0] stub_sr;
  int         stub_cnt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .WIDTH(8), .MAX_BURST(3), .TIMEOUT_CYC(50)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
    .req_data(req_data), .req_ready(req_ready), .tx_en(tx_en), .tx_data(tx_data),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_sr   <= '1;
      stub_done <= 1'b0;
    end else begin
      stub_done <= 1'b0;
      if (tx_en && stub_auto) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 0;
        stub_sr   <= {1'b1, tx_data, 1'b0};
      end else if (stub_busy) begin
        stub_cnt <= stub_cnt + 1;
        if (stub_cnt % 2 == 1) stub_sr <= {1'b1, stub_sr[9:1]};
        if (stub_cnt == 19) begin
          stub_done <= 1'b1;
          stub_busy <= 1'b0;
        end
      end
    end
  end

  assign serial  = stub_busy ? stub_sr[0] : 1'b1;
  assign tx_done = stub_done | man_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle: expects the transfer now, checks the ISSUE cycle after.
  task automatic serve(input string tag, input int id, input logic [7:0] data);
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(1 << id));
    step();
    check({tag, "_tx_en"}, 32'(tx_en), 32'd1);
    check({tag, "_tx_data"}, 32'(tx_data), 32'(data));
    check({tag, "_grant"}, 32'(grant_id), 32'(id));
    check({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_frame(input string tag);
    int k = 0;
    while (tx_done !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check({tag, "_done_seen"}, 32'(tx_done), 32'd1);
    step();
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [7:0] rx;
    rst = 1'b1; req_valid = '0; req_lock = '0; req_data = '0;
    err_clr = 1'b0; stub_auto = 1'b1; man_done = 1'b0;
    step(); step();
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    rst = 1'b0;

    // Single byte from requester 2, serial line decoded from the stub.
    req_valid = 4'b0100; req_data[16 +: 8] = 8'hA5;
    serve("single", 2, 8'hA5);
    req_valid = '0;
    step();
    check("single_tx_en_pulse", 32'(tx_en), 32'd0);
    check("single_start_bit", 32'(serial), 32'd0);
    rx = '0;
    for (int b = 0; b < 8; b++) begin
      step(); step();
      rx[b] = serial;
    end
    step(); step();
    check("single_stop_bit", 32'(serial), 32'd1);
    step(); step();
    check("single_done", 32'(tx_done), 32'd1);
    check("single_busy_at_done", 32'(busy), 32'd1);
    step();
    check("single_busy_fall", 32'(busy), 32'd0);
    check("single_rx_byte", 32'(rx), 32'hA5);

    // Round-robin from reset: 0,1,2,3,0.
    rst = 1'b1; step(); rst = 1'b0;
    req_valid = 4'b1111; req_data = 32'h13121110;
    for (int i = 0; i < 5; i++) begin
      serve("rr", i % 4, 8'(8'h10 + (i % 4)));
      if (i == 4) req_valid = '0;
      finish_frame("rr");
    end

    // Lock with MAX_BURST=3: 1,1,1,0.
    req_valid = 4'b0010; req_lock = 4'b0010; req_data = 32'h00002120;
    serve("lock_a1", 1, 8'h21);
    req_valid = 4'b0011;
    finish_frame("lock_a1");
    serve("lock_a2", 1, 8'h21);
    finish_frame("lock_a2");
    serve("lock_a3", 1, 8'h21);
    finish_frame("lock_a3");
    serve("lock_a4", 0, 8'h20);
    req_valid = '0; req_lock = '0;
    finish_frame("lock_a4");

    // Lock dropped after the 2nd byte: 1,1,0. Lock survives requester 1 going idle.
    req_valid = 4'b0010; req_lock = 4'b0010;
    serve("lock_b1", 1, 8'h21);
    req_valid = 4'b0001;
    finish_frame("lock_b1");
    check("lock_b_hold_ready", 32'(req_ready), 32'd0);
    step();
    check("lock_b_hold_idle", 32'(busy), 32'd0);
    req_valid = 4'b0011;
    serve("lock_b2", 1, 8'h21);
    req_lock = '0;
    finish_frame("lock_b2");
    serve("lock_b3", 0, 8'h20);
    req_valid = '0;
    finish_frame("lock_b3");

    // Watchdog: no tx_done from the stub.
    stub_auto = 1'b0;
    req_valid = 4'b0110; req_data = 32'h00323100;
    serve("wd", 1, 8'h31);
    req_valid = 4'b0100;
    repeat (49) step();
    check("wd_err_before", 32'(timeout_err), 32'd0);
    check("wd_busy_before", 32'(busy), 32'd1);
    step();
    check("wd_err_set", 32'(timeout_err), 32'd1);
    check("wd_busy_after", 32'(busy), 32'd0);
    stub_auto = 1'b1;
    serve("wd_next", 2, 8'h32);
    req_valid = '0;
    finish_frame("wd_next");
    check("wd_err_sticky", 32'(timeout_err), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("wd_err_clr", 32'(timeout_err), 32'd0);

    // tx_done on the timeout cycle wins; spurious tx_done in IDLE is ignored.
    stub_auto = 1'b0;
    req_valid = 4'b0001; req_data = 32'h00000041;
    serve("edge", 0, 8'h41);
    req_valid = '0;
    repeat (49) step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("edge_done_wins_err", 32'(timeout_err), 32'd0);
    check("edge_done_wins_idle", 32'(busy), 32'd0);
    man_done = 1'b1; step(); man_done = 1'b0;
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_tx_en", 32'(tx_en), 32'd0);
    check("spur_err", 32'(timeout_err), 32'd0);
    check("spur_tx_data", 32'(tx_data), 32'h41);

    // err_clr coinciding with a new timeout: the set wins.
    req_valid = 4'b0010; req_data = 32'h00005100;
    serve("setwin", 1, 8'h51);
    req_valid = '0;
    repeat (49) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("setwin_err", 32'(timeout_err), 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    check("setwin_clr", 32'(timeout_err), 32'd0);

    // Reset mid-frame.
    stub_auto = 1'b1;
    req_valid = 4'b0100; req_data = 32'h00660000;
    serve("mid", 2, 8'h66);
    req_valid = '0;
    repeat (5) step();
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_en", 32'(tx_en), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    check("mid_rst_err", 32'(timeout_err), 32'd0);
    step();
    rst = 1'b0;
    req_valid = 4'b0101; req_data = 32'h00660077;
    serve("post_rst", 0, 8'h77);
    req_valid = '0;
    finish_frame("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
